kd_tree_node_sender: RTL
========================

// Module: kd_tree_node_sender
// PURPOSE
//  Transmit side of the internal-node write port of the KD-tree. Accepts
//  narrow beats from the load bus, packs them into INTERNAL_WIDTH-bit node
//  words and streams them as sender_enable/sender_data strobes. Emits exactly
//  NUM_NODES words per load, in node-address order 0..NUM_NODES-1, which
//  matches the receiver's auto-incrementing write address.
// PARAMETERS
//  IN_WIDTH        11  load-bus beat width
//  INTERNAL_WIDTH  22  node word width; must equal k*IN_WIDTH for integer k>=1
//  NUM_NODES       63  words per load (internal nodes of a depth-6 tree)
//  CNT_WIDTH       6   node_count width; 2**CNT_WIDTH >= NUM_NODES
// PORTS
//  clk            in   1               clock
//  rst_n          in   1               synchronous active-low reset
//  start          in   1               1-cycle pulse; begins a load
//  fsm_enable     in   1               top FSM is in the node-load phase; gates emission
//  in_valid       in   1               beat valid
//  in_data        in   IN_WIDTH        beat data; first beat of a word = LSBs
//  in_ready       out  1               beat accepted when in_valid && in_ready
//  sender_enable  out  1               1-cycle strobe; one per node word
//  sender_data    out  INTERNAL_WIDTH  node word, valid while sender_enable=1
//  node_count     out  CNT_WIDTH       words emitted in the current load
//  busy           out  1               state==LOAD
//  done           out  1               state==DONE (level signal)
// BEHAVIOUR
//  - Clock clk. Reset rst_n: synchronous, active-low.
//  - BEATS = INTERNAL_WIDTH/IN_WIDTH. Elaboration fails ($error) if the
//    division has a remainder.
//  - Reset state: IDLE. All outputs 0. Beat counter, pack register, FIFO and
//    counters cleared.
//  - A reset during LOAD aborts the load and discards partial and buffered
//    words. rst_n is shared with the receiver, so both ends restart at
//    address 0.
//  - FSM states: IDLE, LOAD, DONE.
//    - IDLE/DONE -> LOAD on start. Entering LOAD clears node_count, the accept
//      counter, the beat index and the FIFO.
//    - start during LOAD is ignored.
//    - LOAD -> DONE on the cycle the NUM_NODES-th strobe is registered.
//    - DONE holds until the next start.
//  - Input side:
//    - in_ready = LOAD && FIFO not full && accepted_words < NUM_NODES.
//    - Beat b of a word lands in bits [b*IN_WIDTH +: IN_WIDTH].
//    - On the final beat, the completed word is pushed into a 2-entry FIFO.
//    - Beats offered after NUM_NODES words have been accepted are not taken
//      (in_ready=0).
//  - Output side, registered:
//    - If LOAD && fsm_enable && FIFO non-empty: pop, register
//      sender_data <= head and sender_enable <= 1. Otherwise sender_enable <= 0
//      and sender_data holds its last value.
//    - fsm_enable low stalls emission only. Input acceptance continues until
//      the FIFO is full.
//    - Back-to-back strobes are allowed, giving one word per cycle when
//      BEATS=1.
//  - Latency: final beat accepted at cycle N -> sender_enable=1 at cycle N+2
//    (FIFO empty, fsm_enable=1).
//  - FIFO: a push and a pop in the same cycle are legal and leave the count
//    unchanged. The FIFO never overflows, because in_ready is gated.
//  - node_count increments with each strobe. It saturates at NUM_NODES and is
//    held in DONE.
// CONFIGURATION
//  NODE_SENDER_CHECKSUM_EN
//  - Defined: adds output checksum[INTERNAL_WIDTH-1:0], the XOR of every
//    sender_data word strobed this load.
//    - Cleared on start and on reset.
//    - Updated in the same cycle as the strobe register.
//    - Stable while in DONE.
//  - Undefined: the port and its logic are absent. All other behaviour is
//    identical.
// TESTING
//  1 Reset, start, 126 beats (BEATS=2) with in_valid always 1 and fsm_enable=1
//    -> 63 strobes, node_count=63, done=1, busy=0. The data for word k equals
//    {beat 2k+1, beat 2k}.
//  2 Word 0 = beats 0x155, 0x2AA -> sender_data=22'h15_5155 two cycles after
//    the second beat is accepted.
//  3 fsm_enable=0 during LOAD -> no strobes; in_ready drops after 2 words are
//    buffered. fsm_enable=1 -> buffered words emitted in order, back-to-back.
//  4 rst_n=0 after word 10 is emitted -> all outputs 0 next cycle. A new start
//    reloads from node 0 and the count restarts at 0.
//  5 start pulsed mid-load -> no effect. start in DONE -> new load, node_count=0.
//    After 63 words are accepted, extra beats are held off (in_ready=0).
//  6 With NODE_SENDER_CHECKSUM_EN, words 1..63 (word k = k) -> checksum=0
//    in DONE.

Source files
------------

// File: rtl/kd_tree_node_sender.sv
// kd_tree_node_sender: transmit side of the KD-tree internal-node write port.
// Packs IN_WIDTH-bit load-bus beats into INTERNAL_WIDTH-bit node words,
// buffers them in a 2-entry FIFO and strobes exactly NUM_NODES words per load
// in node-address order.
// Optional feature macro: NODE_SENDER_CHECKSUM_EN adds a running XOR checksum
// output of every word strobed during the current load.
module kd_tree_node_sender #(
  parameter int IN_WIDTH       = 11,
  parameter int INTERNAL_WIDTH = 22,
  parameter int NUM_NODES      = 63,
  parameter int CNT_WIDTH      = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      fsm_enable,
  input  logic                      in_valid,
  input  logic [IN_WIDTH-1:0]       in_data,
  output logic                      in_ready,
  output logic                      sender_enable,
  output logic [INTERNAL_WIDTH-1:0] sender_data,
  output logic [CNT_WIDTH-1:0]      node_count,
  output logic                      busy,
  output logic                      done
`ifdef NODE_SENDER_CHECKSUM_EN
  ,
  output logic [INTERNAL_WIDTH-1:0] checksum
`endif
);

  localparam int BEATS  = INTERNAL_WIDTH / IN_WIDTH;
  localparam int BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BIDX_W-1:0]    LAST_BEAT   = BIDX_W'(BEATS - 1);
  localparam logic [BIDX_W-1:0]    BIDX_INC    = BIDX_W'(1);
  localparam logic [CNT_WIDTH:0]   ACC_LIMIT   = (CNT_WIDTH + 1)'(NUM_NODES);
  localparam logic [CNT_WIDTH:0]   ACC_INC     = (CNT_WIDTH + 1)'(1);
  localparam logic [CNT_WIDTH-1:0] LAST_NODE   = CNT_WIDTH'(NUM_NODES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_INC     = CNT_WIDTH'(1);

  // A node word must be an exact whole number of beats.
  if ((INTERNAL_WIDTH % IN_WIDTH) != 0) begin : g_bad_width
    $error("kd_tree_node_sender: INTERNAL_WIDTH must be a multiple of IN_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_r;
  logic [BIDX_W-1:0]         beat_idx_r;
  logic [INTERNAL_WIDTH-1:0] pack_r;
  logic [INTERNAL_WIDTH-1:0] fifo_mem_r [0:1];
  logic                      wr_ptr_r;
  logic                      rd_ptr_r;
  logic [1:0]                fifo_cnt_r;
  logic [CNT_WIDTH:0]        accepted_r;
  logic [CNT_WIDTH-1:0]      node_count_r;
  logic                      sender_enable_r;
  logic [INTERNAL_WIDTH-1:0] sender_data_r;
`ifdef NODE_SENDER_CHECKSUM_EN
  logic [INTERNAL_WIDTH-1:0] checksum_r;

  function automatic logic [INTERNAL_WIDTH-1:0] fold_checksum(
    input logic [INTERNAL_WIDTH-1:0] acc,
    input logic [INTERNAL_WIDTH-1:0] word
  );
    return acc ^ word;
  endfunction
`endif

  logic                      in_ready_s;
  logic                      beat_fire_s;
  logic                      push_s;
  logic                      pop_s;
  logic                      start_load_s;
  logic [INTERNAL_WIDTH-1:0] word_s;
  logic [INTERNAL_WIDTH-1:0] head_s;

  // Handshake decode, beat insertion into the pack word, and FIFO head select.
  always_comb begin
    start_load_s = start && (state_r != ST_LOAD);
    in_ready_s   = (state_r == ST_LOAD) && (fifo_cnt_r != 2'd2) && (accepted_r < ACC_LIMIT);
    beat_fire_s  = in_valid && in_ready_s;
    push_s       = beat_fire_s && (beat_idx_r == LAST_BEAT);
    pop_s        = (state_r == ST_LOAD) && fsm_enable && (fifo_cnt_r != 2'd0);
    word_s       = pack_r;
    word_s[int'(beat_idx_r) * IN_WIDTH +: IN_WIDTH] = in_data;
    head_s       = fifo_mem_r[rd_ptr_r];
  end

  // Load FSM together with the packer, FIFO, counters and registered strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      beat_idx_r      <= '0;
      pack_r          <= '0;
      fifo_mem_r[0]   <= '0;
      fifo_mem_r[1]   <= '0;
      wr_ptr_r        <= 1'b0;
      rd_ptr_r        <= 1'b0;
      fifo_cnt_r      <= 2'd0;
      accepted_r      <= '0;
      node_count_r    <= '0;
      sender_enable_r <= 1'b0;
      sender_data_r   <= '0;
`ifdef NODE_SENDER_CHECKSUM_EN
      checksum_r      <= '0;
`endif
    end else if (start_load_s) begin
      // New load: both ends restart at node address 0.
      state_r         <= ST_LOAD;
      beat_idx_r      <= '0;
      pack_r          <= '0;
      wr_ptr_r        <= 1'b0;
      rd_ptr_r        <= 1'b0;
      fifo_cnt_r      <= 2'd0;
      accepted_r      <= '0;
      node_count_r    <= '0;
      sender_enable_r <= 1'b0;
`ifdef NODE_SENDER_CHECKSUM_EN
      checksum_r      <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_IDLE;
        ST_LOAD: begin
          if (pop_s && (node_count_r == LAST_NODE)) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        ST_DONE: state_r <= ST_DONE;
        default: state_r <= ST_IDLE;
      endcase

      if (beat_fire_s) begin
        pack_r <= word_s;
        if (push_s) begin
          beat_idx_r             <= '0;
          accepted_r             <= accepted_r + ACC_INC;
          fifo_mem_r[wr_ptr_r]   <= word_s;
          wr_ptr_r               <= ~wr_ptr_r;
        end else begin
          beat_idx_r <= beat_idx_r + BIDX_INC;
        end
      end

      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase

      if (pop_s) begin
        rd_ptr_r        <= ~rd_ptr_r;
        sender_enable_r <= 1'b1;
        sender_data_r   <= head_s;
        node_count_r    <= node_count_r + CNT_INC;
`ifdef NODE_SENDER_CHECKSUM_EN
        checksum_r      <= fold_checksum(checksum_r, head_s);
`endif
      end else begin
        sender_enable_r <= 1'b0;
      end
    end
  end

  assign in_ready      = in_ready_s;
  assign sender_enable = sender_enable_r;
  assign sender_data   = sender_data_r;
  assign node_count    = node_count_r;
  assign busy          = (state_r == ST_LOAD);
  assign done          = (state_r == ST_DONE);
`ifdef NODE_SENDER_CHECKSUM_EN
  assign checksum      = checksum_r;
`endif

endmodule
